grid_symbol_renderer: RTL and testbench

Parametrised successor to the fixed 3x3 symbol-drawing path of the card-matching game. Renders a ROWS x COLS grid of symbol cells into the 160x120 VGA adapter, one pixel per clock, from a packed per-cell symbol-code vector. Per-cell hidden (card back) and highlight (selection border) masks are supported. Supports full-grid redraw and single-cell redraw; the single-cell mode serves selection, cancel and match updates. Sits between the game control FSM and the vga_adapter x/y/colour/plot inputs.

---
 rtl/grid_symbol_renderer.sv | 227 ++++++++++++++++++++++
 tb/tb_grid_symbol_renderer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/grid_symbol_renderer.sv
// ---------------------------------------------------------------------------
// grid_symbol_renderer
//   Draws a ROWS x COLS grid of square symbol cells into the 160x120 VGA
//   adapter, one pixel per clock. Either the whole grid (mode=1) or a single
//   cell (mode=0) is redrawn. Every visited pixel is plotted, including the
//   background, so a redraw fully overwrites the cell.
//
// Ports
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   start      draw request, taken only while idle (busy=0, done=0)
//   mode       1 = full grid, 0 = single cell
//   cell_idx   target cell for mode 0 (row-major)
//   symbols    packed cell codes, cell 0 in the MSBs
//   hidden     per-cell card-back mask (bit i = cell i)
//   highlight  per-cell selection-border mask (bit i = cell i)
//   busy       drawing in progress
//   done       one-cycle completion pulse
//   x, y       pixel coordinate
//   colour     pixel colour {R,G,B}
//   plot       pixel write enable
// ---------------------------------------------------------------------------
module grid_symbol_renderer #(
    parameter int ROWS    = 3,
    parameter int COLS    = 3,
    parameter int X0      = 50,
    parameter int Y0      = 30,
    parameter int PITCH_X = 20,
    parameter int PITCH_Y = 20,
    parameter int SYM     = 8,
    parameter int CODE_W  = 2,
    localparam int N      = ROWS * COLS,
    localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                mode,
    input  logic [IW-1:0]       cell_idx,
    input  logic [N*CODE_W-1:0] symbols,
    input  logic [N-1:0]        hidden,
    input  logic [N-1:0]        highlight,
    output logic                busy,
    output logic                done,
    output logic [7:0]          x,
    output logic [6:0]          y,
    output logic [2:0]          colour,
    output logic                plot
);
    localparam int PW = (SYM > 1) ? $clog2(SYM) : 1;
    localparam logic [PW-1:0] PMAX = PW'(SYM - 1);

    typedef enum logic [1:0] {IDLE, DRAW, FIN} state_t;

    state_t              state_q;
    logic                mode_q;
    logic [IW-1:0]       cell_q;
    logic [PW-1:0]       px_q, py_q;
    logic                last_q;
    logic [N*CODE_W-1:0] sym_q;
    logic [N-1:0]        hid_q, hl_q;
    logic                busy_q, done_q, plot_q;
    logic [7:0]          x_q;
    logic [6:0]          y_q;
    logic [2:0]          colour_q;

    // Pixel source: in IDLE the first pixel is computed straight from the
    // request inputs so it appears on the cycle right after acceptance.
    logic [IW-1:0]       src_cell;
    logic [PW-1:0]       src_px, src_py;
    logic [N*CODE_W-1:0] src_sym;
    logic [N-1:0]        src_hid, src_hl;
    logic                cell_ok, border, diag;
    logic [CODE_W-1:0]   code_full;
    logic [1:0]          code;
    int                  row, col;
    logic [7:0]          x_d;
    logic [6:0]          y_d;
    logic [2:0]          colour_d;

    // Counter advance for the pixel after the one currently being emitted
    logic [IW-1:0]       cell_d;
    logic [PW-1:0]       px_d, py_d;
    logic                last_d;
    logic                out_of_range;

    always_comb begin
        if (state_q == IDLE) begin
            src_cell = mode ? '0 : cell_idx;
            src_px   = '0;
            src_py   = '0;
            src_sym  = symbols;
            src_hid  = hidden;
            src_hl   = highlight;
        end else begin
            src_cell = cell_q;
            src_px   = px_q;
            src_py   = py_q;
            src_sym  = sym_q;
            src_hid  = hid_q;
            src_hl   = hl_q;
        end

        cell_ok   = int'(src_cell) < N;
        row       = int'(src_cell) / COLS;
        col       = int'(src_cell) % COLS;
        code_full = '0;
        if (cell_ok) begin
            code_full = CODE_W'(src_sym >> ((N - 1 - int'(src_cell)) * CODE_W));
        end
        // Codes wider than 2 bits alias onto the four base shapes
        code   = 2'(code_full);
        border = (src_px == '0) || (src_py == '0) || (src_px == PMAX) || (src_py == PMAX);
        diag   = (src_px == src_py) || (int'(src_px) + int'(src_py) == SYM - 1);

        if (cell_ok && src_hl[src_cell] && border) begin
            colour_d = 3'b101;
        end else if (cell_ok && src_hid[src_cell]) begin
            colour_d = 3'b111;
        end else begin
            case (code)
                2'd0:    colour_d = 3'b100;
                2'd1:    colour_d = border    ? 3'b010 : 3'b000;
                2'd2:    colour_d = diag      ? 3'b001 : 3'b000;
                default: colour_d = !src_py[0] ? 3'b110 : 3'b000;
            endcase
        end

        x_d = 8'(X0 + col * PITCH_X + int'(src_px));
        y_d = 7'(Y0 + row * PITCH_Y + int'(src_py));

        last_d = (px_q == PMAX) && (py_q == PMAX) && (!mode_q || int'(cell_q) == N - 1);
        cell_d = cell_q;
        px_d   = px_q + PW'(1);
        py_d   = py_q;
        if (px_q == PMAX) begin
            px_d = '0;
            if (py_q == PMAX) begin
                py_d   = '0;
                cell_d = cell_q + IW'(1);
            end else begin
                py_d = py_q + PW'(1);
            end
        end

        out_of_range = !mode && (int'(cell_idx) >= N);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            mode_q   <= 1'b0;
            cell_q   <= '0;
            px_q     <= '0;
            py_q     <= '0;
            last_q   <= 1'b0;
            sym_q    <= '0;
            hid_q    <= '0;
            hl_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            plot_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    plot_q <= 1'b0;
                    if (start) begin
                        mode_q <= mode;
                        cell_q <= mode ? '0 : cell_idx;
                        sym_q  <= symbols;
                        hid_q  <= hidden;
                        hl_q   <= highlight;
                        if (out_of_range) begin
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            // Pixel (0,0) goes out now; counters point at (1,0)
                            busy_q   <= 1'b1;
                            plot_q   <= 1'b1;
                            x_q      <= x_d;
                            y_q      <= y_d;
                            colour_q <= colour_d;
                            px_q     <= PW'(1);
                            py_q     <= '0;
                            last_q   <= 1'b0;
                            state_q  <= DRAW;
                        end
                    end
                end
                DRAW: begin
                    if (last_q) begin
                        busy_q  <= 1'b0;
                        plot_q  <= 1'b0;
                        done_q  <= 1'b1;
                        last_q  <= 1'b0;
                        state_q <= FIN;
                    end else begin
                        x_q      <= x_d;
                        y_q      <= y_d;
                        colour_q <= colour_d;
                        last_q   <= last_d;
                        cell_q   <= cell_d;
                        px_q     <= px_d;
                        py_q     <= py_d;
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign plot   = plot_q;
    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;

endmodule

// File: tb/tb_grid_symbol_renderer.sv
// ---------------------------------------------------------------------------
// Bench for grid_symbol_renderer with default parameters. A queue of expected
// pixels is built from the drawing rules at each request and compared with
// every plotted pixel; timing of busy/plot/done is checked per cycle.
// ---------------------------------------------------------------------------
module tb_grid_symbol_renderer;
    localparam int ROWS = 3, COLS = 3, X0 = 50, Y0 = 30, PX = 20, PY = 20, SYM = 8, CW = 2;
    localparam int N = ROWS * COLS;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [3:0]  cell_idx = '0;
    logic [17:0] symbols = '0;
    logic [8:0]  hidden = '0;
    logic [8:0]  highlight = '0;
    logic        busy, done, plot;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;

    int   checks = 0;
    int   errors = 0;
    pix_t exp_q[$];
    pix_t first_pix, last_pix;

    grid_symbol_renderer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
        .cell_idx(cell_idx), .symbols(symbols), .hidden(hidden),
        .highlight(highlight), .busy(busy), .done(done), .x(x), .y(y),
        .colour(colour), .plot(plot)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected pixel stream straight from the drawing rules
    task automatic build(input logic m, input int idx, input logic [17:0] sym,
                         input logic [8:0] hid, input logic [8:0] hl);
        exp_q.delete();
        for (int c = 0; c < N; c++) begin
            if (m || c == idx) begin
                int code;
                code = int'((sym >> ((N - 1 - c) * CW)) & 18'h3) % 4;
                for (int py = 0; py < SYM; py++) begin
                    for (int px = 0; px < SYM; px++) begin
                        pix_t p;
                        bit bord;
                        bord = (px == 0) || (py == 0) || (px == SYM - 1) || (py == SYM - 1);
                        p.x = 8'(X0 + (c % COLS) * PX + px);
                        p.y = 7'(Y0 + (c / COLS) * PY + py);
                        if (hl[c] && bord)        p.c = 3'b101;
                        else if (hid[c])          p.c = 3'b111;
                        else if (code == 0)       p.c = 3'b100;
                        else if (code == 1)       p.c = bord ? 3'b010 : 3'b000;
                        else if (code == 2)       p.c = (px == py || px + py == SYM - 1) ? 3'b001 : 3'b000;
                        else                      p.c = (py % 2 == 0) ? 3'b110 : 3'b000;
                        exp_q.push_back(p);
                    end
                end
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {busy, done, plot, x, y, colour}, 32'd0);
    endtask

    // One request; optional disturbances after a given number of plotted pixels
    task automatic run_draw(input string name, input logic m, input int idx,
                            input logic [17:0] sym, input logic [8:0] hid, input logic [8:0] hl,
                            input int change_at, input int pulse_at, input int reset_at);
        int  P, npix;
        bit  got_done;
        build(m, idx, sym, hid, hl);
        P = exp_q.size();
        npix = 0;
        got_done = 0;
        @(negedge clk);
        mode = m; cell_idx = 4'(idx); symbols = sym; hidden = hid; highlight = hl; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= P + 20; k++) begin
            if (k > 1) @(negedge clk);
            if (done) begin
                chk({name, ".done_cycle"}, k, P + 1);
                chk({name, ".pixel_count"}, npix, P);
                chk({name, ".idle_after"}, {busy, plot}, 2'b00);
                got_done = 1;
                break;
            end
            chk({name, ".busy_plot"}, {busy, plot}, 2'b11);
            if (plot) begin
                if (npix < P) chk({name, ".pixel"}, {x, y, colour}, exp_q[npix]);
                else          chk({name, ".extra_pixel"}, npix + 1, P);
                if (npix == 0) first_pix = {x, y, colour};
                last_pix = {x, y, colour};
                npix++;
            end
            if (npix == change_at) begin
                symbols = 18'($urandom); hidden = 9'($urandom); highlight = 9'($urandom);
                mode = 1'($urandom); cell_idx = 4'($urandom);
            end
            if (npix == pulse_at) begin
                mode = 1'b0; cell_idx = 4'd0; start = 1'b1;
            end
            if (npix == pulse_at + 1) start = 1'b0;
            if (npix == reset_at) begin
                reset_n = 1'b0;
                #1;
                chk_all_zero({name, ".async_reset"});
                repeat (3) begin
                    @(negedge clk);
                    chk_all_zero({name, ".in_reset"});
                end
                reset_n = 1'b1;
                start = 1'b0;
                $display("draw %s mode=%0d idx=%0d reset after %0d pixels", name, m, idx, npix);
                return;
            end
        end
        start = 1'b0;
        if (!got_done) chk({name, ".timeout"}, 32'd0, 32'd1);
        @(negedge clk);
        chk({name, ".done_pulse_end"}, done, 1'b0);
        $display("draw %s mode=%0d idx=%0d pixels=%0d expected=%0d", name, m, idx, npix, P);
    endtask

    initial begin
        logic [17:0] tp_sym;
        tp_sym = 18'b000010010001011010;

        repeat (3) @(negedge clk);
        chk_all_zero("reset_state");
        reset_n = 1'b1;

        // Full draw from the test plan, with fixed-point checks
        run_draw("full", 1'b1, 0, tp_sym, 9'd0, 9'd0, -1, -1, -1);
        chk("full.first", first_pix, {8'd50, 7'd30, 3'b100});
        chk("full.last_xy", {last_pix.x, last_pix.y}, {8'd97, 7'd77});

        run_draw("hidden4", 1'b0, 4, tp_sym, 9'b000010000, 9'd0, -1, -1, -1);
        chk("hidden4.first", first_pix, {8'd70, 7'd50, 3'b111});
        chk("hidden4.last", last_pix, {8'd77, 7'd57, 3'b111});

        run_draw("hl8", 1'b0, 8, tp_sym, 9'd0, 9'b100000000, -1, -1, -1);
        chk("hl8.first", first_pix, {8'd90, 7'd70, 3'b101});

        run_draw("oor", 1'b0, 9, tp_sym, 9'd0, 9'd0, -1, -1, -1);
        run_draw("busy_pulse", 1'b1, 0, tp_sym, 9'h0a5, 9'h14a, -1, 50, -1);
        run_draw("latch", 1'b1, 0, 18'($urandom), 9'($urandom), 9'($urandom), 10, -1, -1);

        run_draw("reset_mid", 1'b1, 0, tp_sym, 9'd0, 9'd0, -1, -1, 100);
        run_draw("after_reset", 1'b1, 0, tp_sym, 9'd0, 9'd0, -1, -1, -1);
        chk("after_reset.first", {first_pix.x, first_pix.y}, {8'd50, 7'd30});

        for (int r = 0; r < 4; r++)
            run_draw("rand_full", 1'b1, 0, 18'($urandom), 9'($urandom), 9'($urandom), -1, -1, -1);
        for (int r = 0; r < 8; r++)
            run_draw("rand_cell", 1'b0, int'($urandom_range(0, 15)), 18'($urandom),
                     9'($urandom), 9'($urandom), -1, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
